// File: rtl/hazard_sequencer.sv
// Stall/flush/forwarding control for the 5-stage pipe, with a load-use
// bubble FSM, memory-wait watchdog and saturating debug event counters.
module hazard_sequencer #(
    parameter int OPCODEWIDTH = 4,
    parameter int REGWIDTH    = 4,
    parameter int MEMTIMEOUT  = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OPCODEWIDTH-1:0] opcodeD,
    input  logic [REGWIDTH-1:0]    rs1D,
    input  logic [REGWIDTH-1:0]    rs2D,
    input  logic [REGWIDTH-1:0]    rs1E,
    input  logic [REGWIDTH-1:0]    rs2E,
    input  logic [REGWIDTH-1:0]    rdE,
    input  logic [REGWIDTH-1:0]    rdM,
    input  logic [REGWIDTH-1:0]    rdW,
    input  logic                   writeEnableE,
    input  logic                   writeEnableM,
    input  logic                   writeEnableW,
    input  logic                   resultSelectorWBE,
    input  logic                   takeBranchE,
    input  logic                   memBusyM,
    output logic                   stallF,
    output logic                   stallD,
    output logic                   stallE,
    output logic                   stallM,
    output logic                   flushD,
    output logic                   flushE,
    output logic [1:0]             forwardAE,
    output logic [1:0]             forwardBE,
    output logic                   memErr,
    output logic [15:0]            stallCount,
    output logic [15:0]            flushCount
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    localparam logic [OPCODEWIDTH-1:0] LP_BR_FIRST = OPCODEWIDTH'(4'b1011);
    localparam logic [15:0]            LP_WD_LAST  = 16'(MEMTIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_waitCnt;
    logic [15:0] r_stallCount;
    logic [15:0] r_flushCount;
    logic        r_memErr;

    logic w_srcHit;
    logic w_noSrc;
    logic w_loadUse;
    logic w_branch;

    assign w_srcHit = (rdE == rs1D) || (rdE == rs2D);
    assign w_noSrc  = (opcodeD >= LP_BR_FIRST);
    assign w_branch = takeBranchE && !memBusyM;

    // LDSTALL masks detection so the held load-use pair cannot re-stall.
    assign w_loadUse = writeEnableE && resultSelectorWBE && w_srcHit &&
                       !w_noSrc && (r_state != LDSTALL) &&
                       !memBusyM && !takeBranchE;

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        w_next = RUN;
        unique case (1'b1)
            memBusyM: begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                w_next = MEMWAIT;
            end
            w_branch: begin
                flushD = 1'b1;
                flushE = 1'b1;
                w_next = RUN;
            end
            w_loadUse: begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
                w_next = LDSTALL;
            end
            default: begin
                w_next = RUN;
            end
        endcase
    end

    always_comb begin
        forwardAE = 2'b00;
        if (writeEnableM && (rdM == rs1E)) begin
            forwardAE = 2'b10;
        end else if (writeEnableW && (rdW == rs1E)) begin
            forwardAE = 2'b01;
        end
    end

    always_comb begin
        forwardBE = 2'b00;
        if (writeEnableM && (rdM == rs2E)) begin
            forwardBE = 2'b10;
        end else if (writeEnableW && (rdW == rs2E)) begin
            forwardBE = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_waitCnt <= '0;
            r_memErr  <= 1'b0;
        end else if (memBusyM) begin
            if (r_waitCnt != 16'hFFFF) begin
                r_waitCnt <= r_waitCnt + 16'd1;
            end
            if (r_waitCnt == LP_WD_LAST) begin
                r_memErr <= 1'b1;
            end
        end else begin
            r_waitCnt <= '0;
        end
    end

    // Only branch flushes count; load-use bubbles show up in stallCount.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else begin
            if (stallF && (r_stallCount != 16'hFFFF)) begin
                r_stallCount <= r_stallCount + 16'd1;
            end
            if (w_branch && (r_flushCount != 16'hFFFF)) begin
                r_flushCount <= r_flushCount + 16'd1;
            end
        end
    end

    assign stallCount = rst ? 16'd0 : r_stallCount;
    assign flushCount = rst ? 16'd0 : r_flushCount;
    assign memErr     = rst ? 1'b0  : r_memErr;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Random + directed bench for hazard_sequencer against a rule-level model.
module tb_hazard_sequencer;

    localparam int MT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcodeD, rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       writeEnableE, writeEnableM, writeEnableW;
    logic       resultSelectorWBE, takeBranchE, memBusyM;
    logic       stallF, stallD, stallE, stallM, flushD, flushE, memErr;
    logic [1:0] forwardAE, forwardBE;
    logic [15:0] stallCount, flushCount;

    int n_cmp = 0;
    int n_bad = 0;

    // model: "previous cycle inserted a load-use bubble", counters, watchdog
    bit m_bub;
    int m_sc, m_fc, m_wc;
    bit m_err;

    always #5 clk = ~clk;

    hazard_sequencer #(
        .OPCODEWIDTH(4),
        .REGWIDTH   (4),
        .MEMTIMEOUT (MT)
    ) dut (
        .clk(clk), .rst(rst), .opcodeD(opcodeD),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW),
        .writeEnableE(writeEnableE), .writeEnableM(writeEnableM),
        .writeEnableW(writeEnableW), .resultSelectorWBE(resultSelectorWBE),
        .takeBranchE(takeBranchE), .memBusyM(memBusyM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .memErr(memErr), .stallCount(stallCount), .flushCount(flushCount)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [3:0] rs);
        if (writeEnableM && rdM == rs) return 2'b10;
        if (writeEnableW && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        opcodeD = 0; rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0;
        rdE = 0; rdM = 0; rdW = 0;
        writeEnableE = 0; writeEnableM = 0; writeEnableW = 0;
        resultSelectorWBE = 0; takeBranchE = 0; memBusyM = 0;
    endtask

    // One clock: check all outputs at negedge, then advance the model.
    task automatic cycle();
        bit busy, br, lu, stl;
        @(negedge clk);
        busy = memBusyM;
        br   = takeBranchE && !busy;
        lu   = writeEnableE && resultSelectorWBE &&
               (rdE == rs1D || rdE == rs2D) && (opcodeD < 4'd11) &&
               !m_bub && !busy && !takeBranchE;
        stl  = busy || lu;
        check("stallF", stallF, stl);
        check("stallD", stallD, stl);
        check("stallE", stallE, busy);
        check("stallM", stallM, busy);
        check("flushD", flushD, br);
        check("flushE", flushE, br || lu);
        check("forwardAE", forwardAE, fwd(rs1E));
        check("forwardBE", forwardBE, fwd(rs2E));
        check("memErr", memErr, rst ? 1'b0 : m_err);
        check("stallCount", stallCount, rst ? 0 : m_sc);
        check("flushCount", flushCount, rst ? 0 : m_fc);
        @(posedge clk);
        if (rst) begin
            m_bub = 0; m_sc = 0; m_fc = 0; m_wc = 0; m_err = 0;
        end else begin
            m_bub = lu;
            if (stl && m_sc < 65535) m_sc++;
            if (br && m_fc < 65535) m_fc++;
            if (busy && m_wc == MT - 1) m_err = 1;
            m_wc = busy ? ((m_wc < 65535) ? m_wc + 1 : m_wc) : 0;
        end
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        m_bub = 0; m_sc = 0; m_fc = 0; m_wc = 0; m_err = 0;
        @(posedge clk);
        #1;
        cycle();
        check("rst_stallF", stallF, 0);
        check("rst_cnt", stallCount, 0);
        rst = 0;

        // load-use: one bubble, then LDSTALL idle with same D fields
        writeEnableE = 1; resultSelectorWBE = 1; rdE = 3; rs1D = 3;
        #1;
        check("lu_stallF", stallF, 1);
        check("lu_flushE", flushE, 1);
        cycle();
        check("ld_stallF", stallF, 0);
        check("ld_flushE", flushE, 0);
        check("ld_scount", stallCount, 1);
        cycle();

        // load-use and branch together: branch wins
        do_reset();
        writeEnableE = 1; resultSelectorWBE = 1; rdE = 3; rs1D = 3;
        takeBranchE = 1;
        cycle();
        check("br_fcount", flushCount, 1);
        check("br_scount", stallCount, 0);
        takeBranchE = 0;
        #1;
        check("br_next_lu", stallF, 1);

        // forwarding priority
        clear_inputs();
        rdM = 5; rdW = 5; writeEnableM = 1; writeEnableW = 1;
        rs1E = 5; rs2E = 5;
        #1;
        check("fwd_m_a", forwardAE, 2'b10);
        check("fwd_m_b", forwardBE, 2'b10);
        writeEnableM = 0;
        #1;
        check("fwd_w_a", forwardAE, 2'b01);
        writeEnableW = 0;
        #1;
        check("fwd_0_b", forwardBE, 2'b00);
        cycle();

        // branch opcode has no sources: no stall
        do_reset();
        writeEnableE = 1; resultSelectorWBE = 1; rdE = 7; rs1D = 7;
        opcodeD = 4'b1100;
        #1;
        check("op_mask", stallF, 0);
        cycle();

        // watchdog
        do_reset();
        memBusyM = 1;
        for (int i = 0; i < MT; i++) begin
            check("wd_err_low", memErr, 0);
            cycle();
            check("wd_stallM", stallM, 1);
        end
        check("wd_err", memErr, 1);
        check("wd_scount", stallCount, MT);
        memBusyM = 0;
        #1;
        check("wd_release", stallF, 0);
        cycle();
        check("wd_sticky", memErr, 1);

        // stall counter saturation, then reset out of MEMWAIT
        do_reset();
        memBusyM = 1;
        for (int i = 0; i < 65537; i++) cycle();
        check("sat", stallCount, 16'hFFFF);
        rst = 1;
        cycle();
        rst = 0;
        memBusyM = 0;
        #1;
        check("rst_sc", stallCount, 0);
        check("rst_err", memErr, 0);
        check("rst_stall", stallF, 0);
        cycle();

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            rst               = ($urandom_range(0, 63) == 0);
            opcodeD           = 4'($urandom_range(0, 15));
            rs1D              = 4'($urandom_range(0, 3));
            rs2D              = 4'($urandom_range(0, 3));
            rs1E              = 4'($urandom_range(0, 3));
            rs2E              = 4'($urandom_range(0, 3));
            rdE               = 4'($urandom_range(0, 3));
            rdM               = 4'($urandom_range(0, 3));
            rdW               = 4'($urandom_range(0, 3));
            writeEnableE      = 1'($urandom);
            writeEnableM      = 1'($urandom);
            writeEnableW      = 1'($urandom);
            resultSelectorWBE = 1'($urandom);
            takeBranchE       = ($urandom_range(0, 5) == 0);
            memBusyM          = ($urandom_range(0, 9) < 4);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
